// File: rtl/ext_bus_mbc1.sv
// External-bus responder: decodes cartridge ROM/RAM and work RAM, holds the MBC1 bank
// registers and converts each bus machine cycle into at most one req/ack memory transaction.
module ext_bus_mbc1 #(
  parameter int ROM_BANK_BITS = 7,
  parameter int RAM_BANK_BITS = 2,
  parameter int RAM_PRESENT   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  ct,
  input  logic [15:0] bus_a,
  input  logic [7:0]  bus_wdata,
  input  logic        bus_rd,
  input  logic        bus_wr,
  output logic [7:0]  bus_rdata,
  output logic        bus_hit,
  output logic [21:0] mem_a,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        err_late
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  localparam int ROM_MASK_I = (1 << ROM_BANK_BITS) - 1;
  localparam int RAM_MASK_I = (1 << RAM_BANK_BITS) - 1;
  localparam logic [6:0] ROM_MASK = ROM_MASK_I[6:0];
  localparam logic [1:0] RAM_MASK = RAM_MASK_I[1:0];

  state_t      state_q;
  logic        late_q;
  logic [7:0]  rdata_q;
  logic [21:0] mem_a_q;
  logic [7:0]  mem_wdata_q;
  logic        mem_we_q;
  logic        mem_req_q;
  logic        err_late_q;

  logic        ram_en_q, ram_en_d;
  logic [4:0]  bank1_q, bank1_d;
  logic [1:0]  bank2_q, bank2_d;
  logic        mode_q, mode_d;

  logic        is_rom, is_cram, is_wram;
  logic        rd_op, wr_op, cram_ok, mem_tgt, mbc_wr;
  logic [6:0]  rom_bank;
  logic [1:0]  ram_bank;
  logic [21:0] phys_a;

  assign is_rom  = ~bus_a[15];
  assign is_cram = (bus_a[15:13] == 3'b101);
  assign is_wram = (bus_a[15:13] == 3'b110) ||
                   ((bus_a[15:13] == 3'b111) && (bus_a < 16'hFE00));
  assign bus_hit = is_rom | is_cram | is_wram;

  // Simultaneous rd and wr resolve to a write.
  assign wr_op   = bus_wr;
  assign rd_op   = bus_rd & ~bus_wr;
  assign cram_ok = (RAM_PRESENT != 0) && ram_en_q;
  assign mem_tgt = (is_rom & rd_op) |
                   (is_cram & cram_ok & (rd_op | wr_op)) |
                   (is_wram & (rd_op | wr_op));
  assign mbc_wr  = is_rom & bus_wr & (ct == 2'd3);

  always_comb begin
    if (bus_a[14])
      rom_bank = {bank2_q, bank1_q} & ROM_MASK;
    else if (mode_q)
      rom_bank = {bank2_q, 5'd0} & ROM_MASK;
    else
      rom_bank = 7'd0;
    ram_bank = (mode_q ? bank2_q : 2'd0) & RAM_MASK;
    if (is_rom)
      phys_a = {1'b0, rom_bank, bus_a[13:0]};
    else if (is_cram)
      phys_a = {7'b1000000, ram_bank, bus_a[12:0]};
    else
      phys_a = {9'b100000100, bus_a[12:0]};
  end

  always_comb begin
    ram_en_d = ram_en_q;
    bank1_d  = bank1_q;
    bank2_d  = bank2_q;
    mode_d   = mode_q;
    if (mbc_wr) begin
      case (bus_a[14:13])
        2'd0:    ram_en_d = (bus_wdata[3:0] == 4'hA);
        2'd1:    bank1_d  = (bus_wdata[4:0] == 5'd0) ? 5'd1 : bus_wdata[4:0];
        2'd2:    bank2_d  = bus_wdata[1:0];
        default: mode_d   = bus_wdata[0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en_q <= 1'b0;
      bank1_q  <= 5'd1;
      bank2_q  <= 2'd0;
      mode_q   <= 1'b0;
    end else begin
      ram_en_q <= ram_en_d;
      bank1_q  <= bank1_d;
      bank2_q  <= bank2_d;
      mode_q   <= mode_d;
    end
  end

  // A request still open when the next machine cycle starts is late; its data is thrown away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      late_q      <= 1'b0;
      rdata_q     <= 8'hFF;
      mem_a_q     <= 22'd0;
      mem_wdata_q <= 8'd0;
      mem_we_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      err_late_q  <= 1'b0;
    end else begin
      err_late_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if ((ct == 2'd1) && mem_tgt) begin
            mem_a_q     <= phys_a;
            mem_we_q    <= wr_op;
            mem_wdata_q <= bus_wdata;
            mem_req_q   <= 1'b1;
            late_q      <= 1'b0;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            if (late_q || (ct == 2'd0)) begin
              err_late_q <= 1'b1;
              state_q    <= IDLE;
            end else begin
              if (!mem_we_q)
                rdata_q <= mem_rdata;
              state_q <= HOLD;
            end
          end else if (ct == 2'd0) begin
            late_q <= 1'b1;
          end
        end
        HOLD: begin
          if ((ct == 2'd3) || (ct == 2'd0))
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_rdata = (bus_hit && (state_q == HOLD) && !mem_we_q && (ct != 2'd0)) ?
                     rdata_q : 8'hFF;
  assign mem_a     = mem_a_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_req   = mem_req_q;
  assign err_late  = err_late_q;

endmodule

// File: tb/tb_ext_bus_mbc1.sv
// Directed bench for ext_bus_mbc1: drives machine cycles, answers memory requests with a
// programmable ack delay and checks decode, banking, memory transactions and late handling.
module tb_ext_bus_mbc1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  ct;
  logic [15:0] bus_a;
  logic [7:0]  bus_wdata;
  logic        bus_rd, bus_wr;
  logic [7:0]  bus_rdata;
  logic        bus_hit;
  logic [21:0] mem_a;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_req;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        err_late;

  int total = 0;
  int bad   = 0;
  int ack_dly = 0;
  int age = 0;
  int launches = 0;
  int errs = 0;
  logic prev_req = 1'b0;

  logic [7:0]  cap_rdata;
  logic        cap_hit, cap_we;
  logic [21:0] cap_a;
  logic [7:0]  cap_wd;
  int          cap_launch;

  always #5 clk = ~clk;

  ext_bus_mbc1 dut (
    .clk(clk), .rst_n(rst_n), .ct(ct), .bus_a(bus_a), .bus_wdata(bus_wdata),
    .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_rdata(bus_rdata), .bus_hit(bus_hit),
    .mem_a(mem_a), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_req(mem_req),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err_late(err_late)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance ct and play the memory side (ack after ack_dly clocks of mem_req).
  task automatic step();
    @(posedge clk);
    #1;
    ct = ct + 2'd1;
    mem_ack = 1'b0;
    if (err_late) errs++;
    if (mem_req && !prev_req) launches++;
    prev_req = mem_req;
    if (mem_req) begin
      if (age >= ack_dly) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_a[7:0] ^ 8'h3C;
      end
      age++;
    end else begin
      age = 0;
    end
  endtask

  task automatic mcycle(input logic [15:0] a, input logic [7:0] d, input logic rd,
                        input logic wr);
    int l0;
    l0 = launches;
    bus_a = a; bus_wdata = d; bus_rd = rd; bus_wr = wr;
    step(); step(); step();
    #1;
    cap_rdata = bus_rdata; cap_hit = bus_hit; cap_a = mem_a;
    cap_we = mem_we; cap_wd = mem_wdata;
    step();
    bus_rd = 1'b0; bus_wr = 1'b0;
    cap_launch = launches - l0;
  endtask

  initial begin
    rst_n = 1'b0; ct = 2'd0; bus_a = 16'h0000; bus_wdata = 8'h00;
    bus_rd = 1'b0; bus_wr = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_a", mem_a, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_err_late", err_late, 0);
    check("rst_rdata", bus_rdata, 8'hFF);
    rst_n = 1'b1;

    mcycle(16'h4123, 8'h00, 1'b1, 1'b0);
    check("rd4123_a", cap_a, 22'h004123);
    check("rd4123_we", cap_we, 0);
    check("rd4123_data", cap_rdata, 8'h1F);
    check("rd4123_hit", cap_hit, 1);
    check("rd4123_launch", cap_launch, 1);

    mcycle(16'h2000, 8'h00, 1'b0, 1'b1);
    check("wr2000_nolaunch", cap_launch, 0);
    mcycle(16'h4000, 8'h00, 1'b1, 1'b0);
    check("bank0as1_a", cap_a, 22'h004000);
    mcycle(16'h2000, 8'h13, 1'b0, 1'b1);
    mcycle(16'h4000, 8'h02, 1'b0, 1'b1);
    mcycle(16'h7FFF, 8'h00, 1'b1, 1'b0);
    check("bank53_a", cap_a, 22'h14FFFF);
    check("bank53_data", cap_rdata, 8'hC3);

    mcycle(16'hA000, 8'h00, 1'b1, 1'b0);
    check("ramoff_data", cap_rdata, 8'hFF);
    check("ramoff_nolaunch", cap_launch, 0);
    check("ramoff_hit", cap_hit, 1);
    mcycle(16'h0000, 8'h0A, 1'b0, 1'b1);
    mcycle(16'h6000, 8'h01, 1'b0, 1'b1);
    mcycle(16'h4000, 8'h03, 1'b0, 1'b1);
    mcycle(16'hB001, 8'h5A, 1'b0, 1'b1);
    check("ramwr_a", cap_a, 22'h207001);
    check("ramwr_we", cap_we, 1);
    check("ramwr_wd", cap_wd, 8'h5A);
    check("ramwr_launch", cap_launch, 1);
    mcycle(16'hB001, 8'h00, 1'b1, 1'b0);
    check("ramrd_data", cap_rdata, 8'h3D);
    mcycle(16'h0123, 8'h00, 1'b1, 1'b0);
    check("mode1_rom0_a", cap_a, 22'h180123);
    mcycle(16'hC010, 8'h77, 1'b1, 1'b1);
    check("rdwr_is_write", cap_we, 1);
    check("rdwr_a", cap_a, 22'h208010);

    mcycle(16'hE010, 8'h00, 1'b1, 1'b0);
    check("echo_a", cap_a, 22'h208010);
    check("echo_data", cap_rdata, 8'h2C);
    mcycle(16'h8000, 8'h00, 1'b1, 1'b0);
    check("vram_hit", cap_hit, 0);
    check("vram_data", cap_rdata, 8'hFF);
    check("vram_nolaunch", cap_launch, 0);
    mcycle(16'hFE00, 8'h00, 1'b1, 1'b0);
    check("fe00_hit", cap_hit, 0);

    ack_dly = 6;
    mcycle(16'hC005, 8'h00, 1'b1, 1'b0);
    check("late_data", cap_rdata, 8'hFF);
    check("late_launch", cap_launch, 1);
    mcycle(16'hC006, 8'h00, 1'b1, 1'b0);
    check("late_block_launch", cap_launch, 0);
    check("late_block_data", cap_rdata, 8'hFF);
    check("late_err_pending", errs, 0);
    ack_dly = 0;
    mcycle(16'hC007, 8'h00, 1'b1, 1'b0);
    check("late_err_once", errs, 1);
    check("after_late_launch", cap_launch, 1);
    check("after_late_a", cap_a, 22'h208007);
    check("after_late_data", cap_rdata, 8'h3B);

    ack_dly = 100;
    bus_a = 16'h0100; bus_rd = 1'b1;
    step(); step();
    check("midreq_req", mem_req, 1);
    rst_n = 1'b0;
    #1;
    check("midreq_rst_req", mem_req, 0);
    check("midreq_rst_a", mem_a, 0);
    check("midreq_rst_we", mem_we, 0);
    bus_rd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ct = 2'd0; age = 0; prev_req = 1'b0; mem_ack = 1'b0; ack_dly = 0;
    rst_n = 1'b1;
    mcycle(16'h4000, 8'h00, 1'b1, 1'b0);
    check("rst_bank_a", cap_a, 22'h004000);
    mcycle(16'hA000, 8'h00, 1'b1, 1'b0);
    check("rst_ramen_nolaunch", cap_launch, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
